mac_seq_ctrl: RTL and testbench

//  Sequences the 8x8 Wallace-tree multiplier into a vector multiply-accumulate engine.

---
 rtl/mac_seq_ctrl_pkg.sv | 27 ++
 rtl/mac_seq_ctrl_wallace.sv | 38 +++
 rtl/mac_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_mac_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the MAC sequencing controller.
// Also holds the carry-save helpers used by the Wallace reduction tree.
package mac_seq_ctrl_pkg;

  localparam int unsigned MulW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic [MulW-1:0] csa_sum(input logic [MulW-1:0] x,
                                              input logic [MulW-1:0] y,
                                              input logic [MulW-1:0] z);
    return x ^ y ^ z;
  endfunction

  // Dropping the top carry bit is safe: the full product always fits in MulW bits.
  function automatic logic [MulW-1:0] csa_carry(input logic [MulW-1:0] x,
                                                input logic [MulW-1:0] y,
                                                input logic [MulW-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_wallace.sv
// Combinational 8x8 unsigned Wallace-tree multiplier.
// Eight partial-product rows reduce through four 3:2 levels to a final carry-propagate add.
module mac_seq_ctrl_wallace
  import mac_seq_ctrl_pkg::*;
(
  input  logic [7:0]      a_i,
  input  logic [7:0]      b_i,
  output logic [MulW-1:0] prod_o
);

  logic [MulW-1:0] pp [8];
  logic [MulW-1:0] s1a, c1a, s1b, c1b;
  logic [MulW-1:0] s2a, c2a, s2b, c2b;
  logic [MulW-1:0] s3, c3, s4, c4;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = b_i[i] ? ({8'b0, a_i} << i) : '0;
    end
    // 8 rows -> 6
    s1a = csa_sum(pp[0], pp[1], pp[2]);
    c1a = csa_carry(pp[0], pp[1], pp[2]);
    s1b = csa_sum(pp[3], pp[4], pp[5]);
    c1b = csa_carry(pp[3], pp[4], pp[5]);
    // 6 rows -> 4
    s2a = csa_sum(s1a, c1a, s1b);
    c2a = csa_carry(s1a, c1a, s1b);
    s2b = csa_sum(c1b, pp[6], pp[7]);
    c2b = csa_carry(c1b, pp[6], pp[7]);
    // 4 rows -> 3 -> 2
    s3  = csa_sum(s2a, c2a, s2b);
    c3  = csa_carry(s2a, c2a, s2b);
    s4  = csa_sum(s3, c3, c2b);
    c4  = csa_carry(s3, c3, c2b);
    prod_o = s4 + c4;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Vector multiply-accumulate sequencer: streams len operand pairs through a registered
// multiplier into a wide accumulator and presents the sum on a valid/ready result port.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             busy
);

  localparam logic [LEN_W-1:0] CntOne = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [MulW-1:0]  prod_q, prod_d;
  logic             prod_v_q, prod_v_d;

  logic [MulW-1:0]  mul_prod;
  logic [ACC_W:0]   acc_sum;
  logic             beat;

  mac_seq_ctrl_wallace u_mul (
    .a_i    (a),
    .b_i    (b),
    .prod_o (mul_prod)
  );

  assign in_ready  = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

  assign beat    = in_valid & in_ready;
  assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - MulW){1'b0}}, prod_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    prod_d   = prod_q;
    prod_v_d = 1'b0;

    if (prod_v_q) begin
      acc_d = acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (beat) begin
          prod_d   = mul_prod;
          prod_v_d = 1'b1;
          cnt_d    = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = StDrain;
          end
        end
      end
      // One extra cycle so the final registered product lands in the accumulator.
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: a 24-bit and a 16-bit accumulator instance share stimulus.
module tb_mac_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_ready;

  logic        in_ready24, out_valid24, ovf24, busy24;
  logic [23:0] acc24;
  logic        in_ready16, out_valid16, ovf16, busy16;
  logic [15:0] acc16;

  int checks = 0;
  int errors = 0;

  mac_seq_ctrl #(.ACC_W(24), .LEN_W(8)) dut24 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready24),
    .a         (a),
    .b         (b),
    .out_valid (out_valid24),
    .out_ready (out_ready),
    .acc_out   (acc24),
    .ovf       (ovf24),
    .busy      (busy24)
  );

  mac_seq_ctrl #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .a         (a),
    .b         (b),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .acc_out   (acc16),
    .ovf       (ovf16),
    .busy      (busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      len;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [31:0]     exp24;
    logic            exp_ovf24;
    logic [31:0]     exp16;
    logic            exp_ovf16;
  } job_t;

  job_t jobs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Streams one job back-to-back and checks latency, result and the return to idle.
  task automatic run_job(input job_t j, input string tag);
    start = 1'b1;
    len   = j.len;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(j.len); i++) begin
      in_valid = 1'b1;
      a        = j.a[i];
      b        = j.b[i];
      check({tag, " in_ready"}, 32'(in_ready24 & in_ready16), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check({tag, " drain out_valid"}, 32'(out_valid24), 32'd0);
    check({tag, " drain in_ready"}, 32'(in_ready24), 32'd0);
    tick();
    check({tag, " out_valid24"}, 32'(out_valid24), 32'd1);
    check({tag, " out_valid16"}, 32'(out_valid16), 32'd1);
    check({tag, " acc24"}, 32'(acc24), j.exp24);
    check({tag, " ovf24"}, 32'(ovf24), 32'(j.exp_ovf24));
    check({tag, " acc16"}, 32'(acc16), j.exp16);
    check({tag, " ovf16"}, 32'(ovf16), 32'(j.exp_ovf16));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle busy"}, 32'(busy24 | busy16), 32'd0);
  endtask

  initial begin
    job_t j;
    int   beats;
    logic [7:0] pat_a [4];
    logic [7:0] pat_b [4];
    logic pat [7];

    jobs[0] = '{len: 8'd3, a: {8'd0, 8'd255, 8'd5, 8'd3}, b: {8'd0, 8'd255, 8'd6, 8'd4},
                exp24: 32'd65067, exp_ovf24: 1'b0, exp16: 32'd65067, exp_ovf16: 1'b0};
    jobs[1] = '{len: 8'd2, a: {8'd0, 8'd0, 8'd255, 8'd255}, b: {8'd0, 8'd0, 8'd255, 8'd255},
                exp24: 32'd130050, exp_ovf24: 1'b0, exp16: 32'd64514, exp_ovf16: 1'b1};
    jobs[2] = '{len: 8'd1, a: {8'd0, 8'd0, 8'd0, 8'd1}, b: {8'd0, 8'd0, 8'd0, 8'd1},
                exp24: 32'd1, exp_ovf24: 1'b0, exp16: 32'd1, exp_ovf16: 1'b0};
    jobs[3] = '{len: 8'd4, a: {8'd0, 8'd255, 8'd50, 8'd100}, b: {8'd9, 8'd1, 8'd60, 8'd200},
                exp24: 32'd23255, exp_ovf24: 1'b0, exp16: 32'd23255, exp_ovf16: 1'b0};
    jobs[4] = '{len: 8'd3, a: {8'd0, 8'd255, 8'd255, 8'd255}, b: {8'd0, 8'd255, 8'd255, 8'd255},
                exp24: 32'd195075, exp_ovf24: 1'b0, exp16: 32'd64003, exp_ovf16: 1'b1};

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    tick();
    tick();
    check("reset busy", 32'(busy24 | busy16), 32'd0);
    check("reset in_ready", 32'(in_ready24 | in_ready16), 32'd0);
    check("reset out_valid", 32'(out_valid24 | out_valid16), 32'd0);
    check("reset acc24", 32'(acc24), 32'd0);
    check("reset ovf", 32'(ovf24 | ovf16), 32'd0);
    rst = 1'b0;
    tick();

    // Table jobs, each started in the cycle right after the previous handshake.
    for (int k = 0; k < 5; k++) begin
      run_job(jobs[k], $sformatf("job%0d", k));
    end

    // Zero-length job goes straight to DONE.
    check("len0 pre in_ready", 32'(in_ready24), 32'd0);
    start = 1'b1;
    len   = 8'd0;
    tick();
    start = 1'b0;
    check("len0 out_valid", 32'(out_valid24), 32'd1);
    check("len0 in_ready", 32'(in_ready24), 32'd0);
    check("len0 acc24", 32'(acc24), 32'd0);
    check("len0 ovf16", 32'(ovf16), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("len0 idle", 32'(busy24), 32'd0);

    // Gappy input and consumer backpressure: 1+2+...: 2+12+30+56 = 100.
    pat_a = '{8'd1, 8'd3, 8'd5, 8'd7};
    pat_b = '{8'd2, 8'd4, 8'd6, 8'd8};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    beats = 0;
    start = 1'b1;
    len   = 8'd4;
    tick();
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      in_valid = pat[c];
      a = pat[c] ? pat_a[beats] : 8'd99;
      b = pat[c] ? pat_b[beats] : 8'd99;
      if (in_valid && in_ready24) beats++;
      tick();
    end
    in_valid = 1'b0;
    check("gap beats", 32'(beats), 32'd4);
    check("gap drain in_ready", 32'(in_ready24), 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("hold out_valid", 32'(out_valid24), 32'd1);
      check("hold acc24", 32'(acc24), 32'd100);
      check("hold ovf24", 32'(ovf24), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("gap idle", 32'(busy24), 32'd0);

    // Reset mid-job after two of five beats.
    start = 1'b1;
    len   = 8'd5;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a = 8'd2; b = 8'd2;
    tick();
    a = 8'd3; b = 8'd3;
    tick();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("abort busy", 32'(busy24), 32'd0);
    check("abort in_ready", 32'(in_ready24), 32'd0);
    check("abort out_valid", 32'(out_valid24), 32'd0);
    check("abort acc24", 32'(acc24), 32'd0);
    j = '{len: 8'd1, a: {8'd0, 8'd0, 8'd0, 8'd2}, b: {8'd0, 8'd0, 8'd0, 8'd3},
          exp24: 32'd6, exp_ovf24: 1'b0, exp16: 32'd6, exp_ovf16: 1'b0};
    run_job(j, "post_abort");

    // start while RUN and DONE must be ignored: 10*10 + 20*20 = 500.
    start = 1'b1;
    len   = 8'd2;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a = 8'd10; b = 8'd10;
    tick();
    start = 1'b1;
    len   = 8'd7;
    a = 8'd20; b = 8'd20;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("ign drain in_ready", 32'(in_ready24), 32'd0);
    tick();
    check("ign out_valid", 32'(out_valid24), 32'd1);
    check("ign acc24", 32'(acc24), 32'd500);
    start = 1'b1;
    len   = 8'd7;
    tick();
    start = 1'b0;
    check("ign done out_valid", 32'(out_valid24), 32'd1);
    check("ign done acc24", 32'(acc24), 32'd500);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ign idle busy", 32'(busy24), 32'd0);
    tick();
    check("ign stays idle", 32'(busy24), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
